// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and default link constants.
package uart_pkg;

  localparam int unsigned CLK_FQ    = 50000000;
  localparam int unsigned BAUD_RATE = 115200;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    RECOVER
  } rx_state_t;

endpackage

// File: rtl/uart_sync.sv
// Generic two-flop synchroniser with asynchronous active-low reset to a programmable value.
module uart_sync #(
  parameter int unsigned        width   = 1,
  parameter logic [width-1:0]   rst_val = '1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [width-1:0] din,
  output logic [width-1:0] dout
);

  logic [width-1:0] meta_q;
  logic [width-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= rst_val;
      sync_q <= rst_val;
    end else begin
      meta_q <= din;
      sync_q <= meta_q;
    end
  end

  assign dout = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8N1, mid-bit sampling, valid/ack handshake with framing-error and overrun pulses.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned clk_fq    = CLK_FQ,
  parameter int unsigned baud_rate = BAUD_RATE,
  parameter int unsigned div_cnt   = clk_fq / baud_rate,
  parameter int unsigned half_cnt  = div_cnt / 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rxd,
  input  logic       rx_ack,
  output logic [7:0] rxdata,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int unsigned   CW        = $clog2(div_cnt);
  localparam logic [CW-1:0] DIV_LAST  = CW'(div_cnt - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(half_cnt - 1);

  logic rxd_s;

  uart_sync #(
    .width   (1),
    .rst_val (1'b1)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (rxd),
    .dout  (rxd_s)
  );

  rx_state_t     state_q,     state_d;
  logic [CW-1:0] cycle_cnt_q, cycle_cnt_d;
  logic [2:0]    bit_idx_q,   bit_idx_d;
  logic [7:0]    rx_shift_q,  rx_shift_d;
  logic [7:0]    rxdata_q,    rxdata_d;
  logic          rx_valid_q,  rx_valid_d;
  logic          frame_err_q, frame_err_d;
  logic          overrun_q,   overrun_d;
  logic          busy_q,      busy_d;

  always_comb begin
    state_d     = state_q;
    cycle_cnt_d = cycle_cnt_q;
    bit_idx_d   = bit_idx_q;
    rx_shift_d  = rx_shift_q;
    rxdata_d    = rxdata_q;
    rx_valid_d  = rx_valid_q & ~rx_ack;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!rxd_s) begin
          state_d     = START;
          cycle_cnt_d = '0;
        end
      end
      START: begin
        if (cycle_cnt_q == HALF_LAST) begin
          // A line that is high again at mid-start-bit was a glitch.
          if (!rxd_s) begin
            state_d     = DATA;
            cycle_cnt_d = '0;
            bit_idx_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cycle_cnt_d = cycle_cnt_q + CW'(1);
        end
      end
      DATA: begin
        if (cycle_cnt_q == DIV_LAST) begin
          rx_shift_d  = {rxd_s, rx_shift_q[7:1]};
          bit_idx_d   = bit_idx_q + 3'd1;
          cycle_cnt_d = '0;
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
          end
        end else begin
          cycle_cnt_d = cycle_cnt_q + CW'(1);
        end
      end
      STOP: begin
        if (cycle_cnt_q == DIV_LAST) begin
          cycle_cnt_d = '0;
          if (rxd_s) begin
            rxdata_d   = rx_shift_q;
            rx_valid_d = 1'b1;
            overrun_d  = rx_valid_q & ~rx_ack;
            state_d    = IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = RECOVER;
          end
        end else begin
          cycle_cnt_d = cycle_cnt_q + CW'(1);
        end
      end
      RECOVER: begin
        if (rxd_s) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cycle_cnt_q <= '0;
      bit_idx_q   <= '0;
      rx_shift_q  <= '0;
      rxdata_q    <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cycle_cnt_q <= cycle_cnt_d;
      bit_idx_q   <= bit_idx_d;
      rx_shift_q  <= rx_shift_d;
      rxdata_q    <= rxdata_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      busy_q      <= busy_d;
    end
  end

  assign rxdata    = rxdata_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 434 clocks per bit; checks taken on falling edges.
module tb_uart_rx;

  logic       clk;
  logic       rst_n;
  logic       rxd;
  logic       rx_ack;
  logic [7:0] rxdata;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  uart_rx #(
    .clk_fq    (50000000),
    .baud_rate (115200)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rxd       (rxd),
    .rx_ack    (rx_ack),
    .rxdata    (rxdata),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Start bit, 8 data bits LSB first, then the stop level; returns one cycle
  // before the stop-bit sample edge (start edge + 4126 posedges).
  task automatic send_to_sample(input logic [7:0] d, input logic stop_bit);
    rxd = 1'b0;
    cycles(434);
    for (int i = 0; i < 8; i++) begin
      rxd = d[i];
      cycles(434);
    end
    rxd = stop_bit;
    cycles(219);
  endtask

  task automatic finish_stop();
    rxd = 1'b1;
    cycles(300);
  endtask

  task automatic good_frame(input string tag, input logic [7:0] d, input logic exp_ovr);
    send_to_sample(d, 1'b1);
    check({tag, "_busy_pre"}, busy, 1);
    check({tag, "_ovr_pre"}, overrun, 0);
    cycles(1);
    check({tag, "_valid"}, rx_valid, 1);
    check({tag, "_data"}, rxdata, d);
    check({tag, "_ferr"}, frame_err, 0);
    check({tag, "_ovr"}, overrun, exp_ovr);
    check({tag, "_busy_post"}, busy, 0);
  endtask

  task automatic ack_now(input string tag);
    rx_ack = 1'b1;
    cycles(1);
    rx_ack = 1'b0;
    check({tag, "_ack_clear"}, rx_valid, 0);
  endtask

  initial begin
    rst_n  = 1'b0;
    rxd    = 1'b1;
    rx_ack = 1'b0;
    cycles(5);
    check("rst_data", rxdata, 8'h00);
    check("rst_valid", rx_valid, 0);
    check("rst_ferr", frame_err, 0);
    check("rst_ovr", overrun, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    cycles(5);

    // Single frame with exact latency: valid still low one cycle before.
    send_to_sample(8'hA5, 1'b1);
    check("a5_valid_early", rx_valid, 0);
    check("a5_busy_pre", busy, 1);
    cycles(1);
    check("a5_valid", rx_valid, 1);
    check("a5_data", rxdata, 8'hA5);
    check("a5_ferr", frame_err, 0);
    check("a5_busy_post", busy, 0);
    ack_now("a5");
    finish_stop();

    // Glitch: 100 low cycles, rejected at the start-bit centre.
    rxd = 1'b0;
    cycles(100);
    rxd = 1'b1;
    cycles(119);
    check("glitch_busy_hi", busy, 1);
    cycles(1);
    check("glitch_busy_lo", busy, 0);
    check("glitch_valid", rx_valid, 0);
    check("glitch_ferr", frame_err, 0);
    cycles(300);

    // Framing error with line held low, then recovery.
    send_to_sample(8'h3C, 1'b0);
    check("ferr_pre", frame_err, 0);
    cycles(1);
    check("ferr_pulse", frame_err, 1);
    check("ferr_valid", rx_valid, 0);
    check("ferr_data", rxdata, 8'hA5);
    check("ferr_busy", busy, 1);
    cycles(1);
    check("ferr_one_cycle", frame_err, 0);
    cycles(2000);
    check("recover_busy", busy, 1);
    check("recover_no_ferr", frame_err, 0);
    rxd = 1'b1;
    cycles(5);
    check("recover_idle", busy, 0);
    cycles(300);
    good_frame("f55", 8'h55, 1'b0);
    ack_now("f55");
    finish_stop();

    // Overrun: two frames, no ack.
    good_frame("o11", 8'h11, 1'b0);
    finish_stop();
    good_frame("o22", 8'h22, 1'b1);
    cycles(1);
    check("o22_ovr_one_cycle", overrun, 0);
    ack_now("o22");
    finish_stop();

    // Ack in the completion cycle: byte loaded, valid kept, no overrun.
    good_frame("s11", 8'h11, 1'b0);
    finish_stop();
    send_to_sample(8'h22, 1'b1);
    rx_ack = 1'b1;
    cycles(1);
    rx_ack = 1'b0;
    check("s22_ovr", overrun, 0);
    check("s22_valid", rx_valid, 1);
    check("s22_data", rxdata, 8'h22);
    finish_stop();

    // Reset during data bit 4 with an unconsumed byte pending.
    rxd = 1'b0;
    cycles(434);
    for (int i = 0; i < 4; i++) begin
      rxd = i[0];
      cycles(434);
    end
    rxd = 1'b1;
    cycles(200);
    check("mid_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_valid", rx_valid, 0);
    check("mid_rst_data", rxdata, 8'h00);
    rxd = 1'b1;
    cycles(5);
    rst_n = 1'b1;
    cycles(10);
    check("post_rst_busy", busy, 0);

    // Loopback-style frames of all zeros and all ones.
    good_frame("f00", 8'h00, 1'b0);
    ack_now("f00");
    finish_stop();
    good_frame("fff", 8'hFF, 1'b0);
    ack_now("fff");
    finish_stop();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
